mem_stage_lsu: RTL and testbench

MEM-stage load/store unit sitting directly upstream of the word-wide data memory. It takes the EX/MEM request (address, store data, funct3) and drives the memory's word port: addr, data, we, re. It returns sign- or zero-extended load data. The memory has no byte enables, so SB/SH are done as a 3-cycle read-modify-write under a pipeline stall.

---
 rtl/mem_stage_lsu.sv | 141 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit driving a word-wide memory without byte enables
//   Loads complete in the request cycle: the memory read is combinational and the
//   result is extended here. SW is a single write. SB/SH become a 3-cycle
//   read-modify-write: IDLE latches the request, RMW_RD reads and merges, RMW_WR writes.
//   Optional macro LSU_MISALIGN_TRAP_EN adds misaligned-access trapping.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/we/funct3/addr/wdata  EX/MEM load/store request
//   flush                         squash the in-flight request
//   stall                         hold EX/MEM and earlier stages
//   load_data, load_valid         extended load result, valid this cycle
//   oob_err                       registered pulse for a suppressed out-of-range access
//   misalign_err, misalign_addr   (LSU_MISALIGN_TRAP_EN only) pulse and last faulting address
//   mem_addr/wdata/we/re, mem_rdata  word port to the data memory
module mem_stage_lsu #(
   parameter int MEM_AW = 6,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic              flush,
   output logic              stall,
   output logic [31:0]       load_data,
   output logic              load_valid,
   output logic              oob_err,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic              misalign_err,
   output logic [ADDR_W-1:0] misalign_addr,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata
);
   typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] a_q;
   logic [15:0] d_q;
   logic half_q;
   logic [31:0] merge_q, merged;
   logic act, oob, mis, bad, is_word, is_half;
   logic [7:0] rb;
   logic [15:0] rh;
   // reset also masks the combinational strobes so nothing reaches memory while rst_n is low
   assign act = rst_n && state == IDLE && req_valid && !flush;
   assign oob = |req_addr[ADDR_W-1:MEM_AW+2];
   // funct3[1] set covers W and the undefined codes, all handled as word accesses
   assign is_word = req_funct3[1];
   assign is_half = req_funct3[1:0] == 2'b01;
`ifdef LSU_MISALIGN_TRAP_EN
   assign mis = (is_half && req_addr[0]) || (is_word && |req_addr[1:0]);
`else
   assign mis = 1'b0;
`endif
   assign bad = oob || mis;
   assign rb = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
   assign rh = mem_rdata[{req_addr[1], 4'b0000} +: 16];
   always_comb begin
      merged = mem_rdata;
      if (half_q) merged[{a_q[1], 4'b0000} +: 16] = d_q;
      else merged[{a_q[1:0], 3'b000} +: 8] = d_q[7:0];
   end
   always_comb begin
      state_n = state;
      stall = 1'b0;
      mem_we = 1'b0;
      mem_re = 1'b0;
      load_valid = 1'b0;
      load_data = '0;
      mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = req_wdata;
      case (state)
         IDLE: begin
            if (act && !bad) begin
               if (!req_we) begin
                  mem_re = 1'b1;
                  load_valid = 1'b1;
                  load_data = is_word ? mem_rdata :
                              is_half ? {{16{rh[15] & ~req_funct3[2]}}, rh} :
                                        {{24{rb[7] & ~req_funct3[2]}}, rb};
               end else if (is_word) begin
                  mem_we = 1'b1;
               end else begin
                  stall = 1'b1;
                  state_n = RMW_RD;
               end
            end
         end
         RMW_RD: begin
            mem_addr = {a_q[ADDR_W-1:2], 2'b00};
            mem_re = 1'b1;
            stall = 1'b1;
            state_n = flush ? IDLE : RMW_WR;
         end
         RMW_WR: begin
            // past the point of no return: flush no longer cancels the write
            mem_addr = {a_q[ADDR_W-1:2], 2'b00};
            mem_we = 1'b1;
            mem_wdata = merge_q;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q <= '0;
         d_q <= '0;
         half_q <= 1'b0;
         merge_q <= '0;
         oob_err <= 1'b0;
      end else begin
         state <= state_n;
         oob_err <= act && oob;
         if (state == IDLE && state_n == RMW_RD) begin
            a_q <= req_addr;
            d_q <= req_wdata[15:0];
            half_q <= req_funct3[0];
         end
         if (state == RMW_RD) merge_q <= merged;
      end
   end
`ifdef LSU_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_err <= 1'b0;
         misalign_addr <= '0;
      end else begin
         misalign_err <= act && mis;
         if (act && mis) misalign_addr <= req_addr;
      end
   end
`endif
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: vector table, corner-case sequences and randomized ops against a reference memory
module tb_mem_stage_lsu;
   logic clk, rst_n, req_valid, req_we, flush;
   logic [2:0] req_funct3;
   logic [31:0] req_addr, req_wdata, load_data, mem_addr, mem_wdata, mem_rdata;
   logic stall, load_valid, oob_err, mem_we, mem_re;
`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_err;
   logic [31:0] misalign_addr;
`endif
   int checks = 0, errors = 0;
   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];

   mem_stage_lsu #(.MEM_AW(6), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .flush(flush), .stall(stall), .load_data(load_data), .load_valid(load_valid),
      .oob_err(oob_err),
`ifdef LSU_MISALIGN_TRAP_EN
      .misalign_err(misalign_err), .misalign_addr(misalign_addr),
`endif
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[7:2]];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic fl);
      req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; flush = fl;
   endtask

   // one request against the reference memory; expectations come from byte arithmetic
   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic fl);
      int sz, sh;
      logic oob, mis, bad, go;
      logic [31:0] w, v, exp, mask;
      sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      sh = (sz == 1) ? 8 * int'(a[1:0]) : (sz == 2) ? 16 * int'(a[1]) : 0;
      oob = (a >> 2) >= 32'd64;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      bad = oob || mis;
      go = !fl && !bad;
      w = ref_mem[a[7:2]];
      v = w >> sh;
      exp = (sz == 4) ? w :
            (sz == 2) ? (f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]}) :
                        (f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]});
      mask = (sz == 1 ? 32'hFF : 32'hFFFF) << sh;
      drive(1'b1, we, f3, a, wd, fl);
      @(negedge clk);
      if (!go || !we || sz == 4) begin
         chk("op_stall", {31'b0, stall}, 32'd0);
         chk("op_mem_re", {31'b0, mem_re}, {31'b0, go && !we});
         chk("op_mem_we", {31'b0, mem_we}, {31'b0, go && we});
         chk("op_load_valid", {31'b0, load_valid}, {31'b0, go && !we});
         chk("op_load_data", load_data, (go && !we) ? exp : 32'h0);
         if (go) chk("op_mem_addr", mem_addr, a & ~32'h3);
         if (go && we) begin
            chk("op_mem_wdata", mem_wdata, wd);
            ref_mem[a[7:2]] = wd;
         end
         @(posedge clk); #1;
         chk("op_oob_err", {31'b0, oob_err}, {31'b0, !fl && oob});
`ifdef LSU_MISALIGN_TRAP_EN
         chk("op_misalign_err", {31'b0, misalign_err}, {31'b0, !fl && mis});
         if (!fl && mis) chk("op_misalign_addr", misalign_addr, a);
`endif
      end else begin
         chk("rmw1_stall", {31'b0, stall}, 32'd1);
         chk("rmw1_strobes", {30'b0, mem_we, mem_re}, 32'd0);
         @(posedge clk); #1;
         chk("rmw_oob_err", {31'b0, oob_err}, 32'd0);
         @(negedge clk);
         chk("rmw2_stall", {31'b0, stall}, 32'd1);
         chk("rmw2_strobes", {30'b0, mem_we, mem_re}, 32'd1);
         chk("rmw2_addr", mem_addr, a & ~32'h3);
         @(posedge clk); #1;
         @(negedge clk);
         chk("rmw3_stall", {31'b0, stall}, 32'd0);
         chk("rmw3_mem_we", {31'b0, mem_we}, 32'd1);
         chk("rmw3_wdata", mem_wdata, (w & ~mask) | ((wd << sh) & mask));
         ref_mem[a[7:2]] = (w & ~mask) | ((wd << sh) & mask);
         @(posedge clk); #1;
      end
      req_valid = 1'b0; flush = 1'b0;
   endtask

   typedef struct {
      logic v, we;
      logic [2:0] f3;
      logic [31:0] a, wd;
      logic e_we, e_re, e_lv;
      logic [31:0] e_ld, e_wd;
      logic e_oob;
   } vec_t;
   vec_t tbl[12];

   initial begin
      logic we, fl;
      logic [2:0] f3;
      logic [31:0] a;
      tbl[0]  = '{1, 1, 3'd2, 32'h10,  32'hDEADBEEF, 1, 0, 0, 32'h0,        32'hDEADBEEF, 0};
      tbl[1]  = '{1, 0, 3'd2, 32'h10,  32'h0,        0, 1, 1, 32'hDEADBEEF, 32'h0,        0};
      tbl[2]  = '{1, 0, 3'd0, 32'h13,  32'h0,        0, 1, 1, 32'hFFFFFFDE, 32'h0,        0};
      tbl[3]  = '{1, 0, 3'd5, 32'h12,  32'h0,        0, 1, 1, 32'h0000DEAD, 32'h0,        0};
      tbl[4]  = '{1, 0, 3'd1, 32'h10,  32'h0,        0, 1, 1, 32'hFFFFBEEF, 32'h0,        0};
      tbl[5]  = '{1, 0, 3'd4, 32'h11,  32'h0,        0, 1, 1, 32'h000000BE, 32'h0,        0};
      tbl[6]  = '{1, 0, 3'd2, 32'h100, 32'h0,        0, 0, 0, 32'h0,        32'h0,        1};
      tbl[7]  = '{0, 0, 3'd2, 32'h10,  32'h0,        0, 0, 0, 32'h0,        32'h0,        0};
      tbl[8]  = '{1, 1, 3'd2, 32'h104, 32'h12345678, 0, 0, 0, 32'h0,        32'h0,        1};
      tbl[9]  = '{1, 0, 3'd3, 32'h10,  32'h0,        0, 1, 1, 32'hDEADBEEF, 32'h0,        0};
      tbl[10] = '{1, 0, 3'd0, 32'h12,  32'h0,        0, 1, 1, 32'hFFFFFFAD, 32'h0,        0};
      tbl[11] = '{1, 0, 3'd5, 32'h10,  32'h0,        0, 1, 1, 32'h0000BEEF, 32'h0,        0};

      rst_n = 1'b0;
      drive(1'b1, 1'b1, 3'd2, 32'h10, 32'hCAFEF00D, 1'b0);
      @(negedge clk); @(negedge clk);
      chk("rst_strobes", {30'b0, mem_we, mem_re}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_load_valid", {31'b0, load_valid}, 32'd0);
      chk("rst_oob_err", {31'b0, oob_err}, 32'd0);
      chk("rst_load_data", load_data, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
      chk("rst_misalign_addr", misalign_addr, 32'd0);
`endif
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, 1'b0);
         @(negedge clk);
         chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].e_we});
         chk($sformatf("v%0d_mem_re", i), {31'b0, mem_re}, {31'b0, tbl[i].e_re});
         chk($sformatf("v%0d_load_valid", i), {31'b0, load_valid}, {31'b0, tbl[i].e_lv});
         chk($sformatf("v%0d_load_data", i), load_data, tbl[i].e_ld);
         chk($sformatf("v%0d_stall", i), {31'b0, stall}, 32'd0);
         if (tbl[i].e_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].e_wd);
         @(posedge clk); #1;
         chk($sformatf("v%0d_oob_err", i), {31'b0, oob_err}, {31'b0, tbl[i].e_oob});
      end
      req_valid = 1'b0;

      drive(1'b1, 1'b1, 3'd0, 32'h11, 32'hAAAAAA55, 1'b0);
      @(negedge clk);
      chk("sb_c1_stall", {31'b0, stall}, 32'd1);
      chk("sb_c1_strobes", {30'b0, mem_we, mem_re}, 32'd0);
      @(posedge clk); #1; @(negedge clk);
      chk("sb_c2_stall", {31'b0, stall}, 32'd1);
      chk("sb_c2_mem_we", {31'b0, mem_we}, 32'd0);
      @(posedge clk); #1; @(negedge clk);
      chk("sb_c3_stall", {31'b0, stall}, 32'd0);
      chk("sb_c3_mem_we", {31'b0, mem_we}, 32'd1);
      chk("sb_c3_wdata", mem_wdata, 32'hDEAD55EF);
      @(posedge clk); #1;
      req_valid = 1'b0;
      ref_mem[4] = 32'hDEAD55EF;
      do_op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);

      do_op(1'b1, 3'd2, 32'h20, 32'hA5A5A5A5, 1'b0);
      drive(1'b1, 1'b1, 3'd1, 32'h20, 32'h00001234, 1'b0);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_rd_mem_we", {31'b0, mem_we}, 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("flush_rd_after_we", {31'b0, mem_we}, 32'd0);
      chk("flush_rd_after_stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      do_op(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
      drive(1'b1, 1'b1, 3'd1, 32'h20, 32'h00001234, 1'b0);
      @(posedge clk); #1; @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_wr_mem_we", {31'b0, mem_we}, 32'd1);
      chk("flush_wr_wdata", mem_wdata, 32'hA5A51234);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
      ref_mem[8] = 32'hA5A51234;
      do_op(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);

      do_op(1'b1, 3'd2, 32'h30, 32'h11223344, 1'b0);
      drive(1'b1, 1'b1, 3'd0, 32'h30, 32'h00000099, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("arst_stall", {31'b0, stall}, 32'd0);
      chk("arst_strobes", {30'b0, mem_we, mem_re}, 32'd0);
      req_valid = 1'b0;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("arst_no_we_%0d", i), {31'b0, mem_we}, 32'd0);
         @(posedge clk); #1;
      end
      do_op(1'b0, 3'd2, 32'h30, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      do_op(1'b0, 3'd2, 32'h0E, 32'h0, 1'b0);
      chk("misalign_addr_hold", misalign_addr, 32'h0E);
`endif

      for (int i = 0; i < 64; i++) do_op(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0);
      for (int i = 0; i < 300; i++) begin
         a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
         fl = $urandom_range(0, 9) == 0;
         do_op(we, f3, a, $urandom, fl);
      end
      for (int i = 0; i < 64; i++) do_op(1'b0, 3'd2, 32'(i * 4), 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
